// File: rtl/boton_acondicionador.sv
// Synchronises and debounces the raw active-low count/clear buttons and drives the counter's
// ena0_in pulse and active-low clear. Define BOTON_AUTOREPEAT_EN to add hold-to-repeat on count.
module boton_acondicionador #(
    parameter int DEB_CYCLES    = 16,
    parameter int REPEAT_DELAY  = 1000,
    parameter int REPEAT_PERIOD = 200,
    parameter int CNT_W         = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_cnt_raw,
    input  logic btn_clr_raw,
    output logic cnt_level,
    output logic cnt_press,
    output logic cnt_release,
    output logic clr_level,
    output logic ena0_out,
    output logic rstbutton_out
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } btn_state_t;

    localparam int NUM_CH = 2;
    localparam int CH_CNT = 0;
    localparam int CH_CLR = 1;
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [NUM_CH-1:0] raw_vec;
    logic [NUM_CH-1:0] level_vec;
    logic [NUM_CH-1:0] level_next_vec;

    assign raw_vec[CH_CNT] = btn_cnt_raw;
    assign raw_vec[CH_CLR] = btn_clr_raw;

`ifdef BOTON_AUTOREPEAT_EN
    logic cnt_stay_pressed;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic             sync1_reg;
            logic             sync2_reg;
            btn_state_t       state_reg;
            btn_state_t       state_next;
            logic [CNT_W-1:0] deb_cnt_reg;
            logic [CNT_W-1:0] deb_cnt_next;
            logic             level_reg;
            logic             level_next;

            // Synchroniser resets to "released" so leaving reset never looks like a press.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    sync1_reg   <= 1'b1;
                    sync2_reg   <= 1'b1;
                    state_reg   <= IDLE;
                    deb_cnt_reg <= '0;
                    level_reg   <= 1'b0;
                end else begin
                    sync1_reg   <= raw_vec[gi];
                    sync2_reg   <= sync1_reg;
                    state_reg   <= state_next;
                    deb_cnt_reg <= deb_cnt_next;
                    level_reg   <= level_next;
                end
            end

            always_comb begin
                state_next   = state_reg;
                deb_cnt_next = deb_cnt_reg;
                level_next   = level_reg;
                case (state_reg)
                    IDLE: begin
                        if (!sync2_reg) begin
                            state_next   = PRESS_WAIT;
                            deb_cnt_next = '0;
                        end
                    end
                    PRESS_WAIT: begin
                        if (sync2_reg) begin
                            state_next   = IDLE;
                            deb_cnt_next = '0;
                        end else if (deb_cnt_reg == DEB_LAST) begin
                            state_next   = PRESSED;
                            deb_cnt_next = '0;
                            level_next   = 1'b1;
                        end else begin
                            deb_cnt_next = deb_cnt_reg + 1'b1;
                        end
                    end
                    PRESSED: begin
                        if (sync2_reg) begin
                            state_next   = RELEASE_WAIT;
                            deb_cnt_next = '0;
                        end
                    end
                    RELEASE_WAIT: begin
                        // Level stays asserted until the release has been debounced.
                        if (!sync2_reg) begin
                            state_next   = PRESSED;
                            deb_cnt_next = '0;
                        end else if (deb_cnt_reg == DEB_LAST) begin
                            state_next   = IDLE;
                            deb_cnt_next = '0;
                            level_next   = 1'b0;
                        end else begin
                            deb_cnt_next = deb_cnt_reg + 1'b1;
                        end
                    end
                    default: begin
                        state_next   = IDLE;
                        deb_cnt_next = '0;
                    end
                endcase
            end

            assign level_vec[gi]      = level_reg;
            assign level_next_vec[gi] = level_next;

`ifdef BOTON_AUTOREPEAT_EN
            if (gi == CH_CNT) begin : g_hold_tap
                assign cnt_stay_pressed = (state_reg == PRESSED) && (state_next == PRESSED);
            end
`endif
        end
    endgenerate

    // Level only changes on an accepted transition, so its edges are the press/release events.
    logic cnt_press_next;
    logic cnt_release_next;
    logic clr_level_next;
    logic repeat_pulse;

    assign cnt_press_next   = level_next_vec[CH_CNT] & ~level_vec[CH_CNT];
    assign cnt_release_next = ~level_next_vec[CH_CNT] & level_vec[CH_CNT];
    assign clr_level_next   = level_next_vec[CH_CLR];

`ifdef BOTON_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REP_FIRST_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] REP_NEXT_LAST  = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] HOLD_MAX       = {CNT_W{1'b1}};

    logic [CNT_W-1:0] hold_cnt_reg;
    logic [CNT_W-1:0] hold_cnt_next;
    logic             first_done_reg;
    logic             first_done_next;
    logic [CNT_W-1:0] hold_target;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_cnt_reg   <= '0;
            first_done_reg <= 1'b0;
        end else begin
            hold_cnt_reg   <= hold_cnt_next;
            first_done_reg <= first_done_next;
        end
    end

    assign hold_target = first_done_reg ? REP_NEXT_LAST : REP_FIRST_LAST;

    // Hold counter only advances while the count FSM stays in PRESSED, so leaving it stops repeats.
    always_comb begin
        hold_cnt_next   = hold_cnt_reg;
        first_done_next = first_done_reg;
        repeat_pulse    = 1'b0;
        if (cnt_press_next) begin
            hold_cnt_next   = '0;
            first_done_next = 1'b0;
        end else if (cnt_stay_pressed) begin
            if (hold_cnt_reg == hold_target) begin
                repeat_pulse    = 1'b1;
                hold_cnt_next   = '0;
                first_done_next = 1'b1;
            end else if (hold_cnt_reg != HOLD_MAX) begin
                hold_cnt_next = hold_cnt_reg + 1'b1;
            end
        end
    end
`else
    assign repeat_pulse = 1'b0;
`endif

    logic cnt_press_reg;
    logic cnt_release_reg;
    logic ena0_reg;
    logic rstbutton_reg;

    // Clear gates the enable in the same cycle it is accepted, so clear wins on simultaneous presses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_press_reg   <= 1'b0;
            cnt_release_reg <= 1'b0;
            ena0_reg        <= 1'b0;
            rstbutton_reg   <= 1'b0;
        end else begin
            cnt_press_reg   <= cnt_press_next;
            cnt_release_reg <= cnt_release_next;
            ena0_reg        <= (cnt_press_next | repeat_pulse) & ~clr_level_next;
            rstbutton_reg   <= ~clr_level_next;
        end
    end

    assign cnt_level     = level_vec[CH_CNT];
    assign clr_level     = level_vec[CH_CLR];
    assign cnt_press     = cnt_press_reg;
    assign cnt_release   = cnt_release_reg;
    assign ena0_out      = ena0_reg;
    assign rstbutton_out = rstbutton_reg;

endmodule
